datapath_bus_ctrl: RTL and testbench



---
 rtl/datapath_bus_ctrl_pkg.sv | 40 ++++
 rtl/datapath_bus_ctrl_if.sv | 31 +++
 rtl/datapath_bus_ctrl_alu.sv | 54 +++++
 rtl/datapath_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_datapath_bus_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_bus_ctrl_pkg.sv
// rtl/datapath_bus_ctrl_pkg.sv - shared types and constants for the datapath bus controller
package datapath_bus_ctrl_pkg;

  localparam int WORD_WIDTH_DEF  = 8;
  localparam int NUM_B_SRC_DEF   = 9;
  localparam int NUM_C_DST_DEF   = 9;
  localparam int B_SEL_WIDTH_DEF = 4;
  localparam int UOP_ALU_WIDTH   = 6;
  localparam int UOP_SHIFT_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  // Function select is the {F0,F1} pair taken from the top of uop_alu
  typedef enum logic [1:0] {
    FN_AND  = 2'b00,
    FN_OR   = 2'b01,
    FN_NOTB = 2'b10,
    FN_ADD  = 2'b11
  } alu_fn_e;

  localparam int ALU_F0   = 5;
  localparam int ALU_F1   = 4;
  localparam int ALU_ENA  = 3;
  localparam int ALU_ENB  = 2;
  localparam int ALU_INVA = 1;
  localparam int ALU_INC  = 0;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_SLL1 = 2'b01,
    SH_SRA1 = 2'b10,
    SH_BOTH = 2'b11
  } shift_e;

endpackage

// File: rtl/datapath_bus_ctrl_if.sv
// rtl/datapath_bus_ctrl_if.sv - micro-op handshake and register-file B/C bus bundle
interface datapath_bus_ctrl_if
  import datapath_bus_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
  parameter int NUM_B_SRC   = NUM_B_SRC_DEF,
  parameter int NUM_C_DST   = NUM_C_DST_DEF,
  parameter int B_SEL_WIDTH = B_SEL_WIDTH_DEF
);
  logic                       uop_valid;
  logic                       uop_ready;
  logic [B_SEL_WIDTH-1:0]     uop_b_sel;
  logic [UOP_ALU_WIDTH-1:0]   uop_alu;
  logic [UOP_SHIFT_WIDTH-1:0] uop_shift;
  logic [NUM_C_DST-1:0]       uop_c_mask;
  logic                       uop_h_write;
  logic [NUM_B_SRC-1:0]       b_read_enable;
  logic [WORD_WIDTH-1:0]      b_bus;
  logic [WORD_WIDTH-1:0]      c_bus;
  logic [NUM_C_DST-1:0]       c_write_enable;

  modport master (
    input  uop_valid, uop_b_sel, uop_alu, uop_shift, uop_c_mask, uop_h_write, b_bus,
    output uop_ready, b_read_enable, c_bus, c_write_enable
  );

  modport slave (
    output uop_valid, uop_b_sel, uop_alu, uop_shift, uop_c_mask, uop_h_write, b_bus,
    input  uop_ready, b_read_enable, c_bus, c_write_enable
  );
endinterface

// File: rtl/datapath_bus_ctrl_alu.sv
// rtl/datapath_bus_ctrl_alu.sv - combinational ALU, optional shifter and N/Z flags
// Shifter is built only when DATAPATH_BUS_CTRL_SHIFTER_EN is defined.
module datapath_alu
  import datapath_bus_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic [WORD_WIDTH-1:0]      h,
  input  logic [WORD_WIDTH-1:0]      b_lat,
  input  logic [UOP_ALU_WIDTH-1:0]   alu,
  input  logic [UOP_SHIFT_WIDTH-1:0] shift,
  output logic [WORD_WIDTH-1:0]      result,
  output logic                       n,
  output logic                       z
);

  logic [WORD_WIDTH-1:0] a_en;
  logic [WORD_WIDTH-1:0] a_op;
  logic [WORD_WIDTH-1:0] b_op;
  logic [WORD_WIDTH-1:0] alu_out;

  always_comb begin
    a_en = alu[ALU_ENA] ? h : '0;
    a_op = alu[ALU_INVA] ? ~a_en : a_en;
    b_op = alu[ALU_ENB] ? b_lat : '0;
    alu_out = '0;
    case (alu_fn_e'({alu[ALU_F0], alu[ALU_F1]}))
      FN_AND:  alu_out = a_op & b_op;
      FN_OR:   alu_out = a_op | b_op;
      FN_NOTB: alu_out = ~b_op;
      FN_ADD:  alu_out = a_op + b_op + WORD_WIDTH'(alu[ALU_INC]);
      default: alu_out = '0;
    endcase
  end

`ifdef DATAPATH_BUS_CTRL_SHIFTER_EN
  always_comb begin
    result = alu_out;
    case (shift_e'(shift))
      SH_SLL1: result = {alu_out[WORD_WIDTH-2:0], 1'b0};
      SH_SRA1: result = {alu_out[WORD_WIDTH-1], alu_out[WORD_WIDTH-1:1]};
      default: result = alu_out;
    endcase
  end
`else
  logic unused_shift;
  assign unused_shift = ^shift;
  assign result = alu_out;
`endif

  assign n = result[WORD_WIDTH-1];
  assign z = (result == '0);

endmodule

// File: rtl/datapath_bus_ctrl.sv
// rtl/datapath_bus_ctrl.sv - micro-op FSM driving B-bus reads and C-bus writes
// Optional shifter in the ALU is selected by DATAPATH_BUS_CTRL_SHIFTER_EN.
module datapath_bus_ctrl
  import datapath_bus_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
  parameter int NUM_B_SRC   = NUM_B_SRC_DEF,
  parameter int NUM_C_DST   = NUM_C_DST_DEF,
  parameter int B_SEL_WIDTH = B_SEL_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  datapath_bus_ctrl_if.master bus,
  output logic                n_flag,
  output logic                z_flag,
  output logic                done
);

  state_e                     state_q, state_d;
  logic [WORD_WIDTH-1:0]      h_q, h_d;
  logic [WORD_WIDTH-1:0]      b_lat_q, b_lat_d;
  logic [WORD_WIDTH-1:0]      c_bus_q, c_bus_d;
  logic                       n_q, n_d;
  logic                       z_q, z_d;
  logic [B_SEL_WIDTH-1:0]     b_sel_q, b_sel_d;
  logic [UOP_ALU_WIDTH-1:0]   alu_q, alu_d;
  logic [UOP_SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [NUM_C_DST-1:0]       mask_q, mask_d;
  logic                       h_write_q, h_write_d;

  logic [NUM_B_SRC-1:0]       b_en;
  logic [WORD_WIDTH-1:0]      alu_result;
  logic                       alu_n;
  logic                       alu_z;

  datapath_alu #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_alu (
    .h      (h_q),
    .b_lat  (b_lat_q),
    .alu    (alu_q),
    .shift  (shift_q),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z)
  );

  // Out-of-range selects match no bit, so the enable vector stays all-zero
  always_comb begin
    b_en = '0;
    for (int i = 0; i < NUM_B_SRC; i++) begin
      b_en[i] = (state_q == ST_READ_B) && (int'(b_sel_q) == i);
    end
  end

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    b_lat_d   = b_lat_q;
    c_bus_d   = c_bus_q;
    n_d       = n_q;
    z_d       = z_q;
    b_sel_d   = b_sel_q;
    alu_d     = alu_q;
    shift_d   = shift_q;
    mask_d    = mask_q;
    h_write_d = h_write_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.uop_valid) begin
          b_sel_d   = bus.uop_b_sel;
          alu_d     = bus.uop_alu;
          shift_d   = bus.uop_shift;
          mask_d    = bus.uop_c_mask;
          h_write_d = bus.uop_h_write;
          state_d   = ST_READ_B;
        end
      end
      ST_READ_B: begin
        b_lat_d = (|b_en) ? bus.b_bus : '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        c_bus_d = alu_result;
        n_d     = alu_n;
        z_d     = alu_z;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (h_write_q) begin
          h_d = c_bus_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      b_lat_q   <= '0;
      c_bus_q   <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      b_sel_q   <= '0;
      alu_q     <= '0;
      shift_q   <= '0;
      mask_q    <= '0;
      h_write_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      b_lat_q   <= b_lat_d;
      c_bus_q   <= c_bus_d;
      n_q       <= n_d;
      z_q       <= z_d;
      b_sel_q   <= b_sel_d;
      alu_q     <= alu_d;
      shift_q   <= shift_d;
      mask_q    <= mask_d;
      h_write_q <= h_write_d;
    end
  end

  assign bus.uop_ready      = (state_q == ST_IDLE);
  assign bus.b_read_enable  = b_en;
  assign bus.c_bus          = c_bus_q;
  assign bus.c_write_enable = (state_q == ST_WRITE) ? mask_q : '0;
  assign done               = (state_q == ST_WRITE);
  assign n_flag             = n_q;
  assign z_flag             = z_q;

endmodule

// File: tb/tb_datapath_bus_ctrl.sv
// tb/tb_datapath_bus_ctrl.sv - directed self-checking bench for datapath_bus_ctrl
module tb_datapath_bus_ctrl;

  logic clk;
  logic rst_n;
  logic n_flag;
  logic z_flag;
  logic done;
  int   pass_cnt;
  int   total_cnt;

  datapath_bus_ctrl_if bus ();

  datapath_bus_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .n_flag (n_flag),
    .z_flag (z_flag),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] ALU_PASS_B  = 6'b01_0100;
  localparam logic [5:0] ALU_ADD_INC = 6'b11_1101;
  localparam logic [5:0] ALU_ADD     = 6'b11_1100;
  localparam logic [5:0] ALU_PASS_A  = 6'b01_1000;

  task automatic issue(input logic [3:0] sel, input logic [5:0] alu, input logic [1:0] sh,
                       input logic [8:0] mask, input logic hw, input logic [7:0] bval,
                       output logic [8:0] ren, output logic [7:0] cb, output logic [8:0] cwe,
                       output logic nf, output logic zf, output int lat);
    @(negedge clk);
    bus.uop_b_sel   = sel;
    bus.uop_alu     = alu;
    bus.uop_shift   = sh;
    bus.uop_c_mask  = mask;
    bus.uop_h_write = hw;
    bus.b_bus       = bval;
    bus.uop_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.uop_valid = 1'b0;
    ren = bus.b_read_enable;
    lat = 0; cb = '0; cwe = '0; nf = 1'b0; zf = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (lat == 0 && done) begin
        lat = k; cb = bus.c_bus; cwe = bus.c_write_enable; nf = n_flag; zf = z_flag;
      end
      if (lat == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.uop_valid = 1'b0; bus.uop_b_sel = '0; bus.uop_alu = '0; bus.uop_shift = '0;
    bus.uop_c_mask = '0; bus.uop_h_write = 1'b0; bus.b_bus = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.uop_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.uop_ready); else pass_cnt++;
    total_cnt++;
    if ({bus.b_read_enable, bus.c_write_enable} !== 18'h0)
      $display("FAIL reset_enables: got %h/%h want 0/0", bus.b_read_enable, bus.c_write_enable);
    else pass_cnt++;
    total_cnt++;
    if ({bus.c_bus, n_flag, z_flag, done} !== 11'h0)
      $display("FAIL reset_outputs: c_bus=%h n=%b z=%b done=%b want all 0", bus.c_bus, n_flag, z_flag, done);
    else pass_cnt++;
  endtask

  task automatic test_pass_through;
    logic [8:0] ren, cwe; logic [7:0] cb; logic nf, zf; int lat;
    issue(4'd4, ALU_PASS_B, 2'b00, 9'h020, 1'b0, 8'h5A, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if (ren !== 9'h010) $display("FAIL pass_ren: got %h want 010", ren); else pass_cnt++;
    total_cnt++;
    if (cb !== 8'h5A) $display("FAIL pass_cbus: got %h want 5a", cb); else pass_cnt++;
    total_cnt++;
    if (cwe !== 9'h020) $display("FAIL pass_cwe: got %h want 020", cwe); else pass_cnt++;
    total_cnt++;
    if (lat !== 3) $display("FAIL pass_latency: got %0d want 3", lat); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, bus.c_write_enable, bus.uop_ready} !== {1'b0, 9'h0, 1'b1})
      $display("FAIL pass_after_write: done=%b cwe=%h ready=%b want 0/000/1", done, bus.c_write_enable, bus.uop_ready);
    else pass_cnt++;
  endtask

  task automatic test_add_inc;
    logic [8:0] ren, cwe; logic [7:0] cb; logic nf, zf; int lat;
    issue(4'd0, ALU_PASS_B, 2'b00, 9'h000, 1'b1, 8'h7F, ren, cb, cwe, nf, zf, lat);
    issue(4'd1, ALU_ADD_INC, 2'b00, 9'h001, 1'b0, 8'h00, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if (cb !== 8'h80) $display("FAIL addinc_cbus: got %h want 80", cb); else pass_cnt++;
    total_cnt++;
    if ({nf, zf} !== 2'b10) $display("FAIL addinc_flags: got n=%b z=%b want n=1 z=0", nf, zf); else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [8:0] ren, cwe; logic [7:0] cb; logic nf, zf; int lat;
    issue(4'd0, ALU_PASS_B, 2'b00, 9'h000, 1'b1, 8'hFF, ren, cb, cwe, nf, zf, lat);
    issue(4'd8, ALU_ADD, 2'b00, 9'h100, 1'b0, 8'h01, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if (ren !== 9'h100) $display("FAIL wrap_ren: got %h want 100", ren); else pass_cnt++;
    total_cnt++;
    if (cb !== 8'h00) $display("FAIL wrap_cbus: got %h want 00", cb); else pass_cnt++;
    total_cnt++;
    if ({nf, zf} !== 2'b01) $display("FAIL wrap_flags: got n=%b z=%b want n=0 z=1", nf, zf); else pass_cnt++;
  endtask

  task automatic test_shift;
    logic [8:0] ren, cwe; logic [7:0] cb; logic nf, zf; int lat;
    logic [7:0] exp_sra, exp_sll;
`ifdef DATAPATH_BUS_CTRL_SHIFTER_EN
    exp_sra = 8'hC0; exp_sll = 8'h02;
`else
    exp_sra = 8'h81; exp_sll = 8'h81;
`endif
    issue(4'd2, ALU_PASS_B, 2'b10, 9'h004, 1'b0, 8'h81, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if (cb !== exp_sra) $display("FAIL shift_sra: got %h want %h", cb, exp_sra); else pass_cnt++;
    issue(4'd2, ALU_PASS_B, 2'b01, 9'h004, 1'b0, 8'h81, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if (cb !== exp_sll) $display("FAIL shift_sll: got %h want %h", cb, exp_sll); else pass_cnt++;
    issue(4'd2, ALU_PASS_B, 2'b11, 9'h004, 1'b0, 8'h81, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if (cb !== 8'h81) $display("FAIL shift_both: got %h want 81", cb); else pass_cnt++;
  endtask

  task automatic test_invalid_sel;
    logic [8:0] ren, cwe; logic [7:0] cb; logic nf, zf; int lat;
    issue(4'd12, ALU_PASS_B, 2'b00, 9'h001, 1'b0, 8'hA5, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if (ren !== 9'h000) $display("FAIL invalid_ren: got %h want 000", ren); else pass_cnt++;
    total_cnt++;
    if ({cb, zf} !== {8'h00, 1'b1}) $display("FAIL invalid_operand: got c_bus=%h z=%b want 00/1", cb, zf); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int acc_cycle;
    @(negedge clk);
    bus.uop_b_sel = 4'd2; bus.uop_alu = ALU_PASS_B; bus.uop_shift = 2'b00;
    bus.uop_c_mask = 9'h008; bus.uop_h_write = 1'b0; bus.b_bus = 8'h11; bus.uop_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.uop_ready !== 1'b0) $display("FAIL bp_ready_exec: got %b want 0", bus.uop_ready); else pass_cnt++;
    bus.uop_b_sel = 4'd3; bus.b_bus = 8'h22; bus.uop_c_mask = 9'h010;
    @(negedge clk);
    total_cnt++;
    if ({done, bus.c_bus, bus.c_write_enable} !== {1'b1, 8'h11, 9'h008})
      $display("FAIL bp_first_write: done=%b c_bus=%h cwe=%h want 1/11/008", done, bus.c_bus, bus.c_write_enable);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.uop_ready, done} !== 2'b10) $display("FAIL bp_idle: ready=%b done=%b want 1/0", bus.uop_ready, done); else pass_cnt++;
    @(negedge clk);
    bus.uop_valid = 1'b0;
    total_cnt++;
    if (bus.b_read_enable !== 9'h008) $display("FAIL bp_second_ren: got %h want 008", bus.b_read_enable); else pass_cnt++;
    acc_cycle = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (acc_cycle == 0 && done) begin
        acc_cycle = k;
        total_cnt++;
        if ({bus.c_bus, bus.c_write_enable} !== {8'h22, 9'h010})
          $display("FAIL bp_second_write: c_bus=%h cwe=%h want 22/010", bus.c_bus, bus.c_write_enable);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (acc_cycle !== 2) $display("FAIL bp_second_latency: got %0d want 2", acc_cycle); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [8:0] ren, cwe; logic [7:0] cb; logic nf, zf; int lat;
    int strays;
    @(negedge clk);
    bus.uop_b_sel = 4'd5; bus.uop_alu = ALU_PASS_B; bus.uop_shift = 2'b00;
    bus.uop_c_mask = 9'h1FF; bus.uop_h_write = 1'b1; bus.b_bus = 8'h33; bus.uop_valid = 1'b1;
    @(negedge clk);
    bus.uop_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.uop_ready, bus.b_read_enable, bus.c_write_enable, done} !== {1'b1, 9'h0, 9'h0, 1'b0})
      $display("FAIL rstmid_ctrl: ready=%b ren=%h cwe=%h done=%b want 1/000/000/0",
               bus.uop_ready, bus.b_read_enable, bus.c_write_enable, done);
    else pass_cnt++;
    total_cnt++;
    if ({bus.c_bus, n_flag, z_flag} !== 10'h0)
      $display("FAIL rstmid_data: c_bus=%h n=%b z=%b want 00/0/0", bus.c_bus, n_flag, z_flag);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    strays = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.c_write_enable !== 9'h0 || done !== 1'b0) strays++;
    end
    total_cnt++;
    if (strays !== 0) $display("FAIL rstmid_no_write: got %0d stray cycles want 0", strays); else pass_cnt++;
    issue(4'd0, ALU_PASS_A, 2'b00, 9'h001, 1'b0, 8'h00, ren, cb, cwe, nf, zf, lat);
    total_cnt++;
    if ({cb, zf} !== {8'h00, 1'b1}) $display("FAIL rstmid_h_cleared: got c_bus=%h z=%b want 00/1", cb, zf); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_pass_through();
    test_add_inc();
    test_wrap();
    test_shift();
    test_invalid_sel();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
